// File: rtl/png_unfilter.sv
`default_nettype none
// ============================================================================
// Module      : png_unfilter
// Description : PNG scanline reconstruction (un-filter). Takes a type byte and
//               cfg_w data bytes per row and emits raw bytes one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module png_unfilter #(
    parameter int SIZE = 512,
    parameter int BPP  = 1,
    parameter int W_WD = 10,
    parameter int H_WD = 12
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start_i,
    input  logic [W_WD-1:0] cfg_w_i,
    input  logic [H_WD-1:0] cfg_h_i,
    input  logic            dat_val_i,
    input  logic [7:0]      dat_i,
    output logic            dat_rdy_o,
    output logic            out_val_o,
    output logic [7:0]      out_dat_o,
    output logic            out_last_o,
    output logic            done_o,
    output logic            err_o
);

    localparam int IDX_WD = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TYPE = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [W_WD-1:0]       w_q, w_d;
    logic [H_WD-1:0]       h_q, h_d;
    logic [W_WD-1:0]       col_q, col_d;
    logic [H_WD-1:0]       row_q, row_d;
    logic [2:0]            ftype_q, ftype_d;
    logic                  first_row_q, first_row_d;
    logic                  err_q, err_d;
    logic                  out_val_q, out_val_d;
    logic [7:0]            out_dat_q, out_dat_d;
    logic                  out_last_q, out_last_d;
    logic [BPP-1:0][7:0]   a_hist_q, a_hist_d;
    logic [BPP-1:0][7:0]   c_hist_q, c_hist_d;

    logic [7:0]            lbuf_q [SIZE];
    logic                  lb_we;
    logic [IDX_WD-1:0]     lb_idx;

    logic                  accept;
    logic [7:0]            op_a, op_b, op_c;
    logic [8:0]            sum_ab;
    logic signed [9:0]     p_s, da_s, db_s, dc_s, pa_s, pb_s, pc_s;
    logic [7:0]            paeth;
    logic [7:0]            pred;
    logic [7:0]            recon;

    assign dat_rdy_o  = (state_q == S_TYPE) || (state_q == S_DATA);
    assign accept     = dat_val_i && dat_rdy_o;
    assign out_val_o  = out_val_q;
    assign out_dat_o  = out_dat_q;
    assign out_last_o = out_last_q;
    assign done_o     = (state_q == S_DONE);
    assign err_o      = err_q;

    assign lb_idx = col_q[IDX_WD-1:0];
    // Left and upper-left both come from the oldest entry of their histories.
    assign op_a   = a_hist_q[BPP-1];
    assign op_c   = c_hist_q[BPP-1];
    assign op_b   = first_row_q ? 8'h00 : lbuf_q[lb_idx];

    always_comb begin
        sum_ab = {1'b0, op_a} + {1'b0, op_b};
        p_s    = $signed({2'b00, op_a}) + $signed({2'b00, op_b}) - $signed({2'b00, op_c});
        da_s   = p_s - $signed({2'b00, op_a});
        db_s   = p_s - $signed({2'b00, op_b});
        dc_s   = p_s - $signed({2'b00, op_c});
        pa_s   = (da_s < 0) ? -da_s : da_s;
        pb_s   = (db_s < 0) ? -db_s : db_s;
        pc_s   = (dc_s < 0) ? -dc_s : dc_s;
        if ((pa_s <= pb_s) && (pa_s <= pc_s)) begin
            paeth = op_a;
        end else if (pb_s <= pc_s) begin
            paeth = op_b;
        end else begin
            paeth = op_c;
        end
        case (ftype_q)
            3'd1:    pred = op_a;
            3'd2:    pred = op_b;
            3'd3:    pred = sum_ab[8:1];
            3'd4:    pred = paeth;
            default: pred = 8'h00;
        endcase
        recon = dat_i + pred;
    end

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        h_d         = h_q;
        col_d       = col_q;
        row_d       = row_q;
        ftype_d     = ftype_q;
        first_row_d = first_row_q;
        err_d       = err_q;
        out_val_d   = 1'b0;
        out_dat_d   = out_dat_q;
        out_last_d  = 1'b0;
        a_hist_d    = a_hist_q;
        c_hist_d    = c_hist_q;
        lb_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    w_d         = cfg_w_i;
                    h_d         = cfg_h_i;
                    row_d       = '0;
                    err_d       = 1'b0;
                    first_row_d = 1'b1;
                    state_d     = S_TYPE;
                end
            end
            S_TYPE: begin
                if (accept) begin
                    // Unknown filter types pass data through unchanged.
                    if (dat_i > 8'd4) begin
                        ftype_d = 3'd0;
                        err_d   = 1'b1;
                    end else begin
                        ftype_d = dat_i[2:0];
                    end
                    a_hist_d = '0;
                    c_hist_d = '0;
                    col_d    = '0;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    out_val_d = 1'b1;
                    out_dat_d = recon;
                    lb_we     = 1'b1;
                    for (int i = BPP - 1; i > 0; i--) begin
                        a_hist_d[i] = a_hist_q[i-1];
                        c_hist_d[i] = c_hist_q[i-1];
                    end
                    a_hist_d[0] = recon;
                    c_hist_d[0] = op_b;
                    if (col_q == w_q - W_WD'(1)) begin
                        out_last_d  = 1'b1;
                        row_d       = row_q + H_WD'(1);
                        first_row_d = 1'b0;
                        state_d     = (row_q == h_q - H_WD'(1)) ? S_DONE : S_TYPE;
                    end else begin
                        col_d = col_q + W_WD'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            w_q         <= '0;
            h_q         <= '0;
            col_q       <= '0;
            row_q       <= '0;
            ftype_q     <= '0;
            first_row_q <= 1'b1;
            err_q       <= 1'b0;
            out_val_q   <= 1'b0;
            out_dat_q   <= '0;
            out_last_q  <= 1'b0;
            a_hist_q    <= '0;
            c_hist_q    <= '0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            h_q         <= h_d;
            col_q       <= col_d;
            row_q       <= row_d;
            ftype_q     <= ftype_d;
            first_row_q <= first_row_d;
            err_q       <= err_d;
            out_val_q   <= out_val_d;
            out_dat_q   <= out_dat_d;
            out_last_q  <= out_last_d;
            a_hist_q    <= a_hist_d;
            c_hist_q    <= c_hist_d;
        end
    end

    // Previous-row storage; read and overwrite share the column index.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lbuf_q[lb_idx] <= recon;
        end
    end

endmodule
`default_nettype wire
